// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Byte address -> word address shift for 32-bit instruction words.
  localparam int WORD_SHIFT = 2;

  // Widest PC the legality helper accepts; callers zero-extend into it.
  localparam int PC_MAX_W = 64;

  // A PC may be fetched only if it is word-aligned and names a word inside the RAM.
  function automatic logic pc_legal(input logic [PC_MAX_W-1:0] pc,
                                    input logic [PC_MAX_W-1:0] depth);
    return (pc[1:0] == 2'b00) && ((pc >> WORD_SHIFT) < depth);
  endfunction

endpackage

// File: rtl/fetch_unit_imem.sv
// Single-port instruction RAM: synchronous write, synchronous read, no reset.
// The read register only updates on a read strobe, so a stalled fetch keeps its word.
module imem_ram #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Shared port: a write (programming) or a read (fetch), never both in one cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, HALT/RUN/FAULT control, output registers and
// fault detection in front of a synchronous-read instruction RAM.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 256,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int               AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;
  logic              fault_q;
  // Set by the first fetch after reset; until then instr reads as zero
  // because the RAM read register itself has no reset.
  logic              loaded_q;

  logic              pc_ok;
  logic              do_fetch;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign pc_ok    = pc_legal(PC_MAX_W'(pc_q), PC_MAX_W'(DEPTH));
  assign do_fetch = rst_n && (state_q == RUN) && !redirect_valid && !stall && run && pc_ok;
  assign ram_we   = rst_n && (state_q == HALT) && prog_we;
  assign ram_addr = (state_q == HALT) ? prog_addr : pc_q[WORD_SHIFT +: AW];

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_imem (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (do_fetch),
    .addr_i  (ram_addr),
    .wdata_i (prog_data),
    .rdata_o (ram_rdata)
  );

  // Control FSM together with PC and output registers; priority in RUN is
  // redirect > stall > halt request > fetch/fault.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HALT;
      pc_q          <= RESET_PC;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      loaded_q      <= 1'b0;
    end else begin
      case (state_q)
        HALT: begin
          instr_valid_q <= 1'b0;
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end
          if (run) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            pc_q          <= redirect_pc;
            instr_valid_q <= 1'b0;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (!run) begin
            state_q       <= HALT;
            instr_valid_q <= 1'b0;
          end else if (pc_ok) begin
            instr_valid_q <= 1'b1;
            instr_pc_q    <= pc_q;
            pc_q          <= pc_q + PC_STEP;
            loaded_q      <= 1'b1;
          end else begin
            state_q       <= FAULT;
            fault_q       <= 1'b1;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= pc_q;
          end
        end
        FAULT: begin
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park in the terminal fault state.
          state_q       <= FAULT;
          fault_q       <= 1'b1;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = loaded_q ? ram_rdata : '0;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized traffic,
// checked against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              prog_we = 1'b0;
  logic [AW-1:0]     prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              fault;

  fetch_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fault          (fault)
  );

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the fetch rules
  typedef enum {M_HALT, M_RUN, M_FAULT} mstate_e;
  mstate_e     m_state;
  logic [31:0] m_pc;
  logic [31:0] m_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_fault;

  task automatic model_step();
    if (!rst_n) begin
      m_state = M_HALT; m_pc = RESET_PC; m_valid = 1'b0;
      m_instr = 32'h0;  m_ipc = 32'h0;  m_fault = 1'b0;
      return;
    end
    case (m_state)
      M_HALT: begin
        m_valid = 1'b0;
        if (prog_we) m_mem[prog_addr] = prog_data;
        if (redirect_valid) m_pc = redirect_pc;
        if (run) m_state = M_RUN;
      end
      M_RUN: begin
        if (redirect_valid) begin
          m_pc = redirect_pc; m_valid = 1'b0;
        end else if (stall) begin
          m_valid = m_valid;
        end else if (!run) begin
          m_state = M_HALT; m_valid = 1'b0;
        end else if ((m_pc % 4 == 0) && (m_pc / 4 < DEPTH)) begin
          m_instr = m_mem[m_pc / 4]; m_ipc = m_pc; m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end else begin
          m_state = M_FAULT; m_fault = 1'b1; m_valid = 1'b0; m_ipc = m_pc;
        end
      end
      default: m_valid = 1'b0;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, and queue the expected outputs.
  task automatic cycle(input logic r, input logic rn, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic we, input logic [AW-1:0] wa,
                       input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    rst_n = r; run = rn; stall = st; redirect_valid = rv; redirect_pc = rpc;
    prog_we = we; prog_addr = wa; prog_data = wd;
    model_step();
    e.v = m_valid; e.ins = m_instr; e.pc = m_ipc; e.f = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic go();        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0); endtask
  task automatic stl();       cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0); endtask
  task automatic redir(input logic [31:0] a); cycle(1'b1, 1'b1, 1'b0, 1'b1, a, 1'b0, '0, 32'h0); endtask
  task automatic rst();       cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0); endtask

  // Constant expectation straight from the scenario description.
  task automatic direct(input string name, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic f);
    @(posedge clk);
    #2;
    checks++;
    if (instr_valid !== v || instr !== ins || instr_pc !== pc || fault !== f) begin
      errors++;
      $display("FAIL %s: got v=%0b instr=%h pc=%h fault=%0b, expected v=%0b instr=%h pc=%h fault=%0b",
               name, instr_valid, instr, instr_pc, fault, v, ins, pc, f);
    end
  endtask

  // Monitor: one queued expectation per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_valid !== e.v || instr !== e.ins || instr_pc !== e.pc || fault !== e.f) begin
          errors++;
          $display("FAIL scoreboard @%0t: got v=%0b instr=%h pc=%h fault=%0b, expected v=%0b instr=%h pc=%h fault=%0b",
                   $time, instr_valid, instr, instr_pc, fault, e.v, e.ins, e.pc, e.f);
        end
      end
    end
  end

  initial begin
    logic [31:0] w14, w15;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

    rst(); rst();
    direct("reset", 1'b0, 32'h0, 32'h0, 1'b0);

    // Program in HALT: words 0..3 = A0..A3, rest random.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, AW'(i),
            (i < 4) ? (32'hA0 + 32'(i)) : $urandom);
    end
    w14 = m_mem[14]; w15 = m_mem[15];

    go();  direct("start_bubble", 1'b0, 32'h0, 32'h0, 1'b0);
    go();  direct("fetch0", 1'b1, 32'hA0, 32'h0, 1'b0);
    go();  direct("fetch1", 1'b1, 32'hA1, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stl(); direct("stall_hold", 1'b1, 32'hA1, 32'h4, 1'b0);
    end
    go();  direct("fetch2", 1'b1, 32'hA2, 32'h8, 1'b0);
    go();  direct("fetch3", 1'b1, 32'hA3, 32'hC, 1'b0);

    redir(32'h0); direct("redir_bubble", 1'b0, 32'hA3, 32'hC, 1'b0);
    go();  direct("redir_target", 1'b1, 32'hA0, 32'h0, 1'b0);
    go();  direct("refetch1", 1'b1, 32'hA1, 32'h4, 1'b0);
    redir(32'h0); direct("squash", 1'b0, 32'hA1, 32'h4, 1'b0);
    go();  direct("squash_target", 1'b1, 32'hA0, 32'h0, 1'b0);

    // Programming attempt in RUN is ignored.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, AW'(1), 32'hFF);
    redir(32'h4);
    go();  direct("prog_in_run_ignored", 1'b1, 32'hA1, 32'h4, 1'b0);

    // run=0 is ignored under stall, then halts with the PC retained.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0);
    direct("run_ignored_in_stall", 1'b1, 32'hA1, 32'h4, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
    direct("halt", 1'b0, 32'hA1, 32'h4, 1'b0);
    go(); go(); direct("resume_pc", 1'b1, 32'hA2, 32'h8, 1'b0);

    // Reset mid-run clears outputs, keeps RAM, restarts at RESET_PC.
    rst(); direct("midrun_reset", 1'b0, 32'h0, 32'h0, 1'b0);
    go(); go(); direct("ram_retained", 1'b1, 32'hA0, RESET_PC, 1'b0);

    // Run off the end of the RAM.
    redir(32'h38); go(); go();
    direct("last_word", 1'b1, w15, 32'h3C, 1'b0);
    go();  direct("range_fault", 1'b0, w15, 32'h40, 1'b1);

    // Misaligned target faults at its fetch; FAULT is sticky.
    rst(); go(); redir(32'h6);
    direct("misalign_bubble", 1'b0, 32'h0, 32'h0, 1'b0);
    go();  direct("misalign_fault", 1'b0, 32'h0, 32'h6, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, '0, 32'h55);
    go(); go();
    direct("fault_sticky", 1'b0, 32'h0, 32'h6, 1'b1);
    rst(); go(); go();
    direct("fault_prog_ignored", 1'b1, 32'hA0, 32'h0, 1'b0);
    if (w14 == 32'h0) w14 = 32'h0; // keep both captured words referenced

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic r, rn, st, rv, we;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) >= 2);
      rn  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 4) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 15) == 0) ? $urandom : (32'($urandom_range(0, DEPTH-1)) << 2);
      we  = ($urandom_range(0, 3) == 0);
      cycle(r, rn, st, rv, rpc, we, AW'($urandom), $urandom);
    end

    go();
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
